lcd_read_fsm: RTL and testbench

- 4-bit-mode read engine for the Spartan 3E character LCD, complementing the existing instruction (write) FSM on the same SF_D/LCD_E/LCD_RS/LCD_RW pins.
- Performs one read transaction: upper nibble, then lower nibble, with LCD_RW=1. Reads either the busy flag/address (RS=0) or CGRAM/DDRAM data (RS=1).
- Optional poll mode repeats busy-flag reads until BF clears or a poll limit expires.
- The top level muxes pin ownership using `busy`; this block never drives SF_D.

---
 rtl/lcd_read_if.sv | 27 ++
 rtl/lcd_read_fsm.sv | 170 +++++++++++++++++
 tb/tb_lcd_read_fsm.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_read_if.sv
// Pin-level and handshake bundle for the Spartan 3E character-LCD read engine.
// The master drives requests and the LCD data pins. The slave (the read FSM) drives the strobes and results.
interface lcd_read_if;
  logic       start;
  logic       rs_sel;
  logic       poll;
  logic [3:0] SF_D_in;
  logic       LCD_E;
  logic       LCD_RS;
  logic       LCD_RW;
  logic       busy;
  logic [7:0] rd_data;
  logic       busy_flag;
  logic [6:0] addr;
  logic       valid;
  logic       timeout;

  modport master (
    output start, rs_sel, poll, SF_D_in,
    input  LCD_E, LCD_RS, LCD_RW, busy, rd_data, busy_flag, addr, valid, timeout
  );

  modport slave (
    input  start, rs_sel, poll, SF_D_in,
    output LCD_E, LCD_RS, LCD_RW, busy, rd_data, busy_flag, addr, valid, timeout
  );
endinterface

// File: rtl/lcd_read_fsm.sv
// 4-bit-mode LCD read engine: one upper/lower nibble read with RW=1, plus an
// optional busy-flag poll loop. It never drives SF_D. Pin strobes are registered from next state.
module lcd_read_fsm #(
  parameter int SETUP_CYC  = 2,
  parameter int E_HIGH_CYC = 12,
  parameter int HOLD_CYC   = 1,
  parameter int GAP_CYC    = 50,
  parameter int POLL_MAX   = 255,
  parameter int CNT_W      = 8
) (
  input logic   clk,
  input logic   reset,
  lcd_read_if.slave bus
);

  localparam int PC_W = $clog2(POLL_MAX + 1);

  localparam logic [3:0] S_IDLE        = 4'd0;
  localparam logic [3:0] S_SETUP_HIGH  = 4'd1;
  localparam logic [3:0] S_ACTIVE_HIGH = 4'd2;
  localparam logic [3:0] S_HOLD_HIGH   = 4'd3;
  localparam logic [3:0] S_GAP         = 4'd4;
  localparam logic [3:0] S_SETUP_LOW   = 4'd5;
  localparam logic [3:0] S_ACTIVE_LOW  = 4'd6;
  localparam logic [3:0] S_HOLD_LOW    = 4'd7;
  localparam logic [3:0] S_DONE        = 4'd8;

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] E_LAST     = CNT_W'(E_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
  localparam logic [PC_W-1:0]  POLL_LIM   = PC_W'(POLL_MAX);

  logic [3:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [PC_W-1:0]  r_poll_cnt;
  logic             r_rs;
  logic             r_poll;
  logic             r_repeat;
  logic [7:0]       r_shift;

  logic             r_lcd_e;
  logic             r_lcd_rs;
  logic             r_lcd_rw;
  logic             r_busy;
  logic [7:0]       r_rd_data;
  logic             r_busy_flag;
  logic [6:0]       r_addr;
  logic             r_valid;
  logic             r_timeout;

  logic [3:0]       w_next;
  logic             w_rs;
  logic [PC_W-1:0]  w_poll_inc;
  logic             w_bf_set;
  logic             w_repeat;
  logic             w_timeout_hit;
  logic             w_accept;
  logic             w_publish;

  assign w_accept      = (r_state == S_IDLE) && bus.start;
  assign w_rs          = (r_state == S_IDLE) ? bus.rs_sel : r_rs;
  assign w_poll_inc    = r_poll_cnt + PC_W'(1);
  assign w_bf_set      = r_poll && r_shift[7];
  assign w_repeat      = w_bf_set && (w_poll_inc < POLL_LIM);
  assign w_timeout_hit = w_bf_set && !(w_poll_inc < POLL_LIM);
  assign w_publish     = (r_state == S_DONE) && !w_repeat;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:        if (bus.start)          w_next = S_SETUP_HIGH;
      S_SETUP_HIGH:  if (r_cnt == SETUP_LAST) w_next = S_ACTIVE_HIGH;
      S_ACTIVE_HIGH: if (r_cnt == E_LAST)     w_next = S_HOLD_HIGH;
      S_HOLD_HIGH:   if (r_cnt == HOLD_LAST)  w_next = S_GAP;
      // The same gap serves both the inter-nibble pause and the poll re-read pause.
      S_GAP:         if (r_cnt == GAP_LAST)   w_next = r_repeat ? S_SETUP_HIGH : S_SETUP_LOW;
      S_SETUP_LOW:   if (r_cnt == SETUP_LAST) w_next = S_ACTIVE_LOW;
      S_ACTIVE_LOW:  if (r_cnt == E_LAST)     w_next = S_HOLD_LOW;
      S_HOLD_LOW:    if (r_cnt == HOLD_LAST)  w_next = S_DONE;
      S_DONE:        w_next = w_repeat ? S_GAP : S_IDLE;
      default:       w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_poll_cnt <= '0;
      r_rs       <= 1'b0;
      r_poll     <= 1'b0;
      r_repeat   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state || r_state == S_IDLE)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + CNT_W'(1);

      if (w_accept) begin
        r_rs       <= bus.rs_sel;
        r_poll     <= bus.poll && !bus.rs_sel;
        r_poll_cnt <= '0;
        r_repeat   <= 1'b0;
      end else if (r_state == S_DONE && w_repeat) begin
        r_poll_cnt <= w_poll_inc;
        r_repeat   <= 1'b1;
      end else if (r_state == S_GAP && w_next == S_SETUP_HIGH) begin
        r_repeat   <= 1'b0;
      end
    end
  end

  // Nibble capture happens on the final E-high cycle, so data settles for the full strobe.
  always_ff @(posedge clk) begin
    if (r_state == S_ACTIVE_HIGH && r_cnt == E_LAST)
      r_shift[7:4] <= bus.SF_D_in;
    if (r_state == S_ACTIVE_LOW && r_cnt == E_LAST)
      r_shift[3:0] <= bus.SF_D_in;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_lcd_e  <= 1'b0;
      r_lcd_rs <= 1'b0;
      r_lcd_rw <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_lcd_e  <= (w_next == S_ACTIVE_HIGH) || (w_next == S_ACTIVE_LOW);
      r_lcd_rs <= (w_next != S_IDLE) && w_rs;
      r_lcd_rw <= (w_next != S_IDLE);
      r_busy   <= (w_next != S_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rd_data   <= '0;
      r_busy_flag <= 1'b0;
      r_addr      <= '0;
      r_valid     <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_valid <= w_publish;
      if (w_accept)
        r_timeout <= 1'b0;
      else if (w_publish && w_timeout_hit)
        r_timeout <= 1'b1;
      if (w_publish) begin
        r_rd_data <= r_shift;
        if (!r_rs) begin
          r_busy_flag <= r_shift[7];
          r_addr      <= r_shift[6:0];
        end
      end
    end
  end

  assign bus.LCD_E     = r_lcd_e;
  assign bus.LCD_RS    = r_lcd_rs;
  assign bus.LCD_RW    = r_lcd_rw;
  assign bus.busy      = r_busy;
  assign bus.rd_data   = r_rd_data;
  assign bus.busy_flag = r_busy_flag;
  assign bus.addr      = r_addr;
  assign bus.valid     = r_valid;
  assign bus.timeout   = r_timeout;

endmodule

// File: tb/tb_lcd_read_fsm.sv
// Randomized bench for lcd_read_fsm: an LCD pin model answers each E strobe from a byte
// queue, and a transaction-level model predicts the published result and the pin timing.
module tb_lcd_read_fsm;
  localparam int SETUP_CYC  = 2;
  localparam int E_HIGH_CYC = 12;
  localparam int HOLD_CYC   = 1;
  localparam int GAP_CYC    = 50;
  localparam int POLL_MAX   = 4;
  localparam int TXN_CYC    = 2 * (SETUP_CYC + E_HIGH_CYC + HOLD_CYC) + GAP_CYC + 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lcd_read_if bus();

  lcd_read_fsm #(
    .SETUP_CYC(SETUP_CYC), .E_HIGH_CYC(E_HIGH_CYC), .HOLD_CYC(HOLD_CYC),
    .GAP_CYC(GAP_CYC), .POLL_MAX(POLL_MAX), .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] lcd_q[$];
  logic       cur_rs = 1'b0;
  int cyc = 0, busy_cyc = 0, busy_rise = 0, e_rise = 0, e_pulses = 0, e_run = 0;
  int gap_run = 0, first_gap = 0, e_bad = 0, rsrw_bad = 0, valid_cnt = 0, valid_busy = 0;
  logic prev_e = 1'b0, prev_busy = 1'b0;

  logic [7:0] m_rd = 8'h00;
  logic       m_bf = 1'b0;
  logic [6:0] m_addr = 7'h00;

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // LCD pin model and protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    int nidx;
    logic [7:0] b;
    cyc++;
    if (bus.busy) begin
      busy_cyc++;
      if (bus.LCD_RS !== cur_rs || bus.LCD_RW !== 1'b1) rsrw_bad++;
      if (!prev_busy) busy_rise = cyc;
    end
    if (bus.valid) begin
      valid_cnt++;
      if (bus.busy) valid_busy++;
    end
    if (bus.LCD_E) begin
      if (!prev_e) begin
        e_pulses++;
        e_run = 0;
        if (e_pulses == 1) e_rise = cyc;
        if (e_pulses == 2) first_gap = gap_run;
        nidx = e_pulses - 1;
        b = (nidx / 2 < lcd_q.size()) ? lcd_q[nidx / 2] : 8'hFF;
        bus.SF_D_in = (nidx % 2 == 0) ? b[7:4] : b[3:0];
      end
      e_run++;
    end else begin
      if (prev_e) begin
        if (e_run != E_HIGH_CYC) e_bad++;
        gap_run = 0;
      end
      gap_run++;
      bus.SF_D_in = 4'($urandom);
    end
    prev_e = bus.LCD_E;
    prev_busy = bus.busy;
  end

  task automatic clear_mon();
    busy_cyc = 0; e_pulses = 0; e_bad = 0; rsrw_bad = 0;
    valid_cnt = 0; valid_busy = 0; first_gap = 0; busy_rise = 0; e_rise = 0;
  endtask

  task automatic run_txn(input logic rs, input logic pl, input bit pulse_mid);
    int k;
    int budget;
    int exp_busy;
    bit got;
    bit eff;
    logic [7:0] pub;
    logic exp_to;
    eff = pl && !rs;
    k = 0;
    while (eff && lcd_q[k][7] && (k + 1) < POLL_MAX) k++;
    pub = lcd_q[k];
    exp_to = eff && pub[7];
    exp_busy = TXN_CYC + k * (GAP_CYC + TXN_CYC);
    budget = exp_busy + 20;

    @(posedge clk); #1;
    clear_mon();
    cur_rs = rs;
    bus.start = 1'b1; bus.rs_sel = rs; bus.poll = pl;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.rs_sel = 1'($urandom); bus.poll = 1'($urandom);
    chk_eq("busy_after_accept", int'(bus.busy), 1);
    chk_eq("timeout_cleared", int'(bus.timeout), 0);
    if (pulse_mid) begin
      repeat (30) @(posedge clk);
      #1 bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(posedge clk); #1;
      if (bus.valid) got = 1'b1;
    end
    chk_eq("valid_seen", int'(got), 1);
    m_rd = pub;
    if (!rs) begin
      m_bf = pub[7];
      m_addr = pub[6:0];
    end
    chk_eq("rd_data", int'(bus.rd_data), int'(m_rd));
    chk_eq("busy_flag", int'(bus.busy_flag), int'(m_bf));
    chk_eq("addr", int'(bus.addr), int'(m_addr));
    chk_eq("timeout", int'(bus.timeout), int'(exp_to));
    chk_eq("busy_at_valid", int'(bus.busy), 0);
    repeat (4) @(posedge clk);
    #1;
    chk_eq("valid_pulses", valid_cnt, 1);
    chk_eq("valid_during_busy", valid_busy, 0);
    chk_eq("busy_cycles", busy_cyc, exp_busy);
    chk_eq("e_pulses", e_pulses, 2 * (k + 1));
    chk_eq("e_width_errors", e_bad, 0);
    chk_eq("rs_rw_errors", rsrw_bad, 0);
    chk_eq("e_nibble_gap", first_gap, HOLD_CYC + GAP_CYC + SETUP_CYC);
    chk_eq("e_first_rise", e_rise - busy_rise, SETUP_CYC);
    chk_eq("rd_data_stable", int'(bus.rd_data), int'(m_rd));
  endtask

  task automatic fill_q(input bit bf_bias);
    lcd_q.delete();
    for (int i = 0; i < POLL_MAX; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      if (bf_bias && ($urandom % 4 != 0)) v[7] = 1'b1;
      lcd_q.push_back(v);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.rs_sel = 1'b0; bus.poll = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_lcd_e", int'(bus.LCD_E), 0);
    chk_eq("rst_lcd_rs", int'(bus.LCD_RS), 0);
    chk_eq("rst_lcd_rw", int'(bus.LCD_RW), 0);
    chk_eq("rst_busy", int'(bus.busy), 0);
    chk_eq("rst_valid", int'(bus.valid), 0);
    chk_eq("rst_timeout", int'(bus.timeout), 0);
    chk_eq("rst_rd_data", int'(bus.rd_data), 0);
    chk_eq("rst_addr", int'({bus.busy_flag, bus.addr}), 0);
    reset = 1'b1;

    lcd_q = '{8'hA5};
    run_txn(1'b1, 1'b0, 1'b0);
    lcd_q = '{8'h84};
    run_txn(1'b0, 1'b0, 1'b0);
    lcd_q = '{8'h9C, 8'hC3, 8'hFF, 8'h02};
    run_txn(1'b0, 1'b1, 1'b0);
    lcd_q = '{8'h80, 8'h81, 8'h9F, 8'hC0};
    run_txn(1'b0, 1'b1, 1'b0);
    lcd_q = '{8'h3C};
    run_txn(1'b1, 1'b1, 1'b1);

    for (int t = 0; t < 10; t++) begin
      logic rs;
      logic pl;
      rs = 1'($urandom);
      pl = 1'($urandom);
      fill_q(pl);
      run_txn(rs, pl, 1'($urandom));
    end

    // Reset on the fifth E-high cycle of a data read.
    lcd_q = '{8'h5A};
    @(posedge clk); #1;
    clear_mon();
    cur_rs = 1'b1;
    bus.start = 1'b1; bus.rs_sel = 1'b1; bus.poll = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 20 && !bus.LCD_E; i++) begin
      @(posedge clk); #1;
    end
    chk_eq("rst_mid_e_seen", int'(bus.LCD_E), 1);
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    chk_eq("rst_mid_lcd_e", int'(bus.LCD_E), 0);
    chk_eq("rst_mid_busy", int'(bus.busy), 0);
    chk_eq("rst_mid_rs_rw", int'({bus.LCD_RS, bus.LCD_RW}), 0);
    chk_eq("rst_mid_rd_data", int'(bus.rd_data), 0);
    chk_eq("rst_mid_valid", int'(bus.valid), 0);
    m_rd = 8'h00; m_bf = 1'b0; m_addr = 7'h00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    chk_eq("rst_mid_no_valid", valid_cnt, 0);
    lcd_q = '{8'h27};
    run_txn(1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
